// File: rtl/axis_tx_framer_if.sv
// rtl/axis_tx_framer_if.sv - FIFO read-side and AXI-Stream master signals of the TX framer
interface axis_tx_framer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_vld;
    logic             fifo_rdy;
    logic [WIDTH-1:0] axis_tdata;
    logic             axis_tvalid;
    logic             axis_tlast;
    logic             axis_tready;

    // master: the framer (pops the FIFO, drives the stream)
    modport master (
        input  fifo_data, fifo_vld, axis_tready,
        output fifo_rdy, axis_tdata, axis_tvalid, axis_tlast
    );

    // slave: the FIFO plus the stream sink around the framer
    modport slave (
        output fifo_data, fifo_vld, axis_tready,
        input  fifo_rdy, axis_tdata, axis_tvalid, axis_tlast
    );
endinterface

// File: rtl/axis_tx_framer.sv
// rtl/axis_tx_framer.sv - pops cfg_len FIFO words and emits them as one AXIS packet
// Optional stall counter output enabled by AXIS_TX_FRAMER_STALL_CNT_EN.
module axis_tx_framer #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
`ifdef AXIS_TX_FRAMER_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    axis_tx_framer_if.master bus
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] pop_cnt;
    logic [LEN_W-1:0] snd_cnt;
    logic [WIDTH-1:0] tdata_q;
    logic             tvalid_q;
    logic             tlast_q;
    logic             pop;
    logic             accept;

    assign bus.axis_tdata  = tdata_q;
    assign bus.axis_tvalid = tvalid_q;
    assign bus.axis_tlast  = tlast_q;

    // Pop only when the output register is empty or draining this cycle.
    assign bus.fifo_rdy = (state == SEND) && (pop_cnt < len_q) && (!tvalid_q || bus.axis_tready);
    assign pop          = bus.fifo_rdy && bus.fifo_vld;
    assign accept       = tvalid_q && bus.axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            len_q    <= '0;
            pop_cnt  <= '0;
            snd_cnt  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            len_q    <= '0;
            pop_cnt  <= '0;
            snd_cnt  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (cfg_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= SEND;
                            len_q   <= cfg_len;
                            pop_cnt <= '0;
                            snd_cnt <= '0;
                        end
                    end
                end
                SEND: begin
                    if (accept && tlast_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Accept and pop together reload the register without a bubble.
            if (pop) begin
                tdata_q  <= bus.fifo_data;
                tvalid_q <= 1'b1;
                tlast_q  <= (pop_cnt == len_q - LEN_W'(1));
                pop_cnt  <= pop_cnt + LEN_W'(1);
            end else if (accept) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            if (accept) begin
                snd_cnt <= snd_cnt + LEN_W'(1);
            end
        end
    end

    cnt_order_a: assert property (@(posedge clk) disable iff (!rst_n)
        (snd_cnt <= pop_cnt) && (pop_cnt <= len_q));

`ifdef AXIS_TX_FRAMER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clear || (state == IDLE && start)) begin
            stall_cnt <= '0;
        end else if (tvalid_q && !bus.axis_tready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
